// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide unit with start/busy/done handshake
//   Ports: clock, reset (async active-low), start, op[1:0] (00 mult, 01 multu, 10 div, 11 divu),
//          a, b (operands, captured on the accepted start), busy, done (one-cycle pulse),
//          hi/lo (product halves, or remainder/quotient), exc (divide exception), counter (debug).
//   MULDIV_DIV_EN: when defined the divide datapath is built; otherwise divide ops raise exc.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         hi,
  output logic [WIDTH-1:0]         lo,
  output logic                     exc,
  output logic [$clog2(WIDTH):0]   counter
);
  localparam int W = WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state;
  logic [2*W-1:0] acc;
  logic [W-1:0] opnd;
  logic dz, neg_p;
  logic sa, sb, go_fix;
  logic [W-1:0] ma, mb;
  logic [W:0] msum;
  logic [2*W-1:0] prod;
  assign sa = ~op[0] & a[W-1];
  assign sb = ~op[0] & b[W-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
  // multiply: acc upper half accumulates, lower half holds the multiplier shifting out LSB first
  assign msum = {1'b0, acc[2*W-1:W]} + {1'b0, acc[0] ? opnd : {W{1'b0}}};
  assign prod = neg_p ? -acc : acc;
`ifdef MULDIV_DIV_EN
  // divide: acc lower half holds the dividend shifting out MSB first, quotient bits shift in
  logic is_div, neg_r;
  logic [W:0] rem, trial, diff;
  logic [W-1:0] quo, rmd;
  assign go_fix = op[1] && b == '0;
  assign trial = {rem[W-1:0], acc[W-1]};
  assign diff = trial - {1'b0, opnd};
  assign quo = neg_p ? -acc[W-1:0] : acc[W-1:0];
  assign rmd = neg_r ? -rem[W-1:0] : rem[W-1:0];
`else
  assign go_fix = op[1];
`endif
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      exc <= 1'b0;
      hi <= '0;
      lo <= '0;
      counter <= '0;
      acc <= '0;
      opnd <= '0;
      dz <= 1'b0;
      neg_p <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div <= 1'b0;
      neg_r <= 1'b0;
      rem <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          exc <= 1'b0;
          counter <= '0;
          dz <= go_fix;
          neg_p <= sa ^ sb;
          state <= go_fix ? FIX : RUN;
`ifdef MULDIV_DIV_EN
          is_div <= op[1];
          neg_r <= sa;
          rem <= '0;
          // on a zero divisor the raw dividend rides in acc so FIX can return it in hi
          acc <= {{W{1'b0}}, go_fix ? a : op[1] ? ma : mb};
          opnd <= op[1] ? mb : ma;
`else
          acc <= {{W{1'b0}}, mb};
          opnd <= ma;
`endif
        end
        RUN: begin
          counter <= counter + 1'b1;
          state <= (counter == W - 1) ? FIX : RUN;
`ifdef MULDIV_DIV_EN
          acc <= is_div ? {acc[2*W-1:W], acc[W-2:0], ~diff[W]} : {msum, acc[W-1:1]};
          rem <= is_div ? (diff[W] ? trial : diff) : rem;
`else
          acc <= {msum, acc[W-1:1]};
`endif
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          state <= DONE;
          if (dz) begin
            exc <= 1'b1;
`ifdef MULDIV_DIV_EN
            hi <= acc[W-1:0];
            lo <= '1;
`else
            hi <= '0;
            lo <= '0;
`endif
          end
`ifdef MULDIV_DIV_EN
          else if (is_div) begin
            hi <= rmd;
            lo <= quo;
          end
`endif
          else begin
            hi <= prod[2*W-1:W];
            lo <= prod[W-1:0];
          end
        end
        default: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (WIDTH=32)
module tb_muldiv_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic busy, done, exc;
  logic [31:0] hi, lo;
  logic [5:0] counter;
  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .exc(exc), .counter(counter)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // runs one operation; returns latency (edges from accept to done cycle, +1) and results
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic [31:0] rh, output logic [31:0] rl,
                       output logic re);
    int bad_busy;
    @(negedge clock);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0; a = ~x; b = ~y; op = ~o;
    lat = 0;
    bad_busy = 0;
    while (!done && lat < 100) begin
      if (!busy) bad_busy++;
      @(posedge clock);
      #1;
      lat++;
    end
    check("busy_run", bad_busy, 0);
    check("busy_done", busy, 0);
    lat = done ? lat + 1 : -1;
    rh = hi; rl = lo; re = exc;
    @(posedge clock);
    #1;
    check("done_pulse", done, 0);
  endtask

  int lat;
  logic [31:0] rh, rl;
  logic re;
  int seen;

  initial begin
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_exc", exc, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_cnt", counter, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    do_op(2'b00, 32'hFFFFFFFD, 32'd5, lat, rh, rl, re);
    check("mult_lat", lat, 34);
    check("mult_hi", rh, 32'hFFFFFFFF);
    check("mult_lo", rl, 32'hFFFFFFF1);
    check("mult_exc", re, 0);

    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, rh, rl, re);
    check("multu_hi", rh, 32'hFFFFFFFE);
    check("multu_lo", rl, 32'h00000001);

    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, rh, rl, re);
    check("mults_hi", rh, 0);
    check("mults_lo", rl, 1);

    do_op(2'b00, 32'h80000000, 32'h80000000, lat, rh, rl, re);
    check("mneg_hi", rh, 32'h40000000);
    check("mneg_lo", rl, 0);

    do_op(2'b01, 32'd100, 32'd7, lat, rh, rl, re);
    check("mu100_lat", lat, 34);
    check("mu100_hi", rh, 0);
    check("mu100_lo", rl, 700);

`ifdef MULDIV_DIV_EN
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, rh, rl, re);
    check("div_lat", lat, 34);
    check("div_lo", rl, 32'hFFFFFFFD);
    check("div_hi", rh, 32'hFFFFFFFF);
    check("div_exc", re, 0);

    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, rh, rl, re);
    check("dovf_lo", rl, 32'h80000000);
    check("dovf_hi", rh, 0);
    check("dovf_exc", re, 0);

    do_op(2'b10, 32'd7, 32'hFFFFFFFE, lat, rh, rl, re);
    check("dneg_lo", rl, 32'hFFFFFFFD);
    check("dneg_hi", rh, 1);

    do_op(2'b11, 32'd100, 32'd7, lat, rh, rl, re);
    check("divu_lo", rl, 14);
    check("divu_hi", rh, 2);

    do_op(2'b11, 32'd7, 32'd0, lat, rh, rl, re);
    check("dz_lat", lat, 2);
    check("dz_hi", rh, 7);
    check("dz_lo", rl, 32'hFFFFFFFF);
    check("dz_exc", re, 1);
`else
    do_op(2'b11, 32'd100, 32'd7, lat, rh, rl, re);
    check("nodiv_lat", lat, 2);
    check("nodiv_hi", rh, 0);
    check("nodiv_lo", rl, 0);
    check("nodiv_exc", re, 1);

    do_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, rh, rl, re);
    check("nodivs_lat", lat, 2);
    check("nodivs_exc", re, 1);
`endif

    do_op(2'b01, 32'd2, 32'd3, lat, rh, rl, re);
    check("clr_exc", re, 0);
    check("clr_lo", rl, 6);
    check("clr_lat", lat, 34);

    // a second start mid-operation must be dropped
    @(negedge clock);
    op = 2'b01; a = 32'd11; b = 32'd13; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 0;
    while (!done && seen < 100) begin
      @(posedge clock);
      #1;
      seen++;
    end
    check("ign_done", done, 1);
    check("ign_lo", lo, 143);
    @(posedge clock);
    #1;
    check("ign_idle", busy, 0);

    // abort by reset partway through a multiply
    @(negedge clock);
    op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_exc", exc, 0);
    @(negedge clock);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) seen++;
    end
    check("abort_nodone", seen, 0);

    do_op(2'b01, 32'd4, 32'd5, lat, rh, rl, re);
    check("post_lat", lat, 34);
    check("post_lo", rl, 20);
    check("post_hi", rh, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
